// File: rtl/el2_trace_capture.sv
// Instruction-trace capture buffer: stores retired-instruction records in a circular
// buffer and streams each one out as a burst of 32-bit words. Optional timestamp: TRACE_TSTAMP_EN.
module el2_trace_capture #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     trace_en,
  input  logic                     trace_rv_i_valid_ip,
  input  logic [31:0]              trace_rv_i_insn_ip,
  input  logic [31:0]              trace_rv_i_address_ip,
  input  logic                     trace_rv_i_exception_ip,
  input  logic [4:0]               trace_rv_i_ecause_ip,
  input  logic                     trace_rv_i_interrupt_ip,
  input  logic [31:0]              trace_rv_i_tval_ip,
  input  logic                     tr_clear,
  input  logic                     tr_rd_ready,
  output logic                     tr_rd_valid,
  output logic [31:0]              tr_rd_data,
  output logic                     tr_rd_last,
  output logic [$clog2(DEPTH):0]   tr_count,
  output logic                     tr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
`ifdef TRACE_TSTAMP_EN
  localparam logic TS_PRESENT = 1'b1;
`else
  localparam logic TS_PRESENT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]       addr;
    logic [31:0]       insn;
    logic [31:0]       tval;
    logic              exc;
    logic              intr;
    logic [4:0]        ecause;
    logic [DROP_W-1:0] drop;
`ifdef TRACE_TSTAMP_EN
    logic [31:0]       tstamp;
`endif
  } entry_t;

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_TSTAMP = 3'd1,
    S_ADDR   = 3'd2,
    S_INSN   = 3'd3,
    S_TVAL   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  entry_t            mem_q [DEPTH];
`ifdef TRACE_TSTAMP_EN
  logic [31:0]       tstamp_q, tstamp_d;
`endif

  entry_t rd_entry;
  entry_t wr_entry;
  logic   empty, full, has_tval, hs, pop_now, push, drop_ev;
  logic [7:0] drop8;
  state_t nxt_state;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_entry = mem_q[rd_ptr_q];
  assign has_tval = rd_entry.exc | rd_entry.intr;
  assign drop8    = 8'(rd_entry.drop);

  // Readout: outputs are a pure function of registered state, so they hold while stalled.
  always_comb begin
    tr_rd_valid = !empty;
    tr_rd_data  = '0;
    tr_rd_last  = 1'b0;
    nxt_state   = S_HDR;
    if (!empty) begin
      case (state_q)
        S_HDR: begin
          tr_rd_data = {8'hA5, drop8, rd_entry.exc, rd_entry.intr, rd_entry.ecause,
                        has_tval, TS_PRESENT, 7'b0};
          nxt_state  = TS_PRESENT ? S_TSTAMP : S_ADDR;
        end
`ifdef TRACE_TSTAMP_EN
        S_TSTAMP: begin
          tr_rd_data = rd_entry.tstamp;
          nxt_state  = S_ADDR;
        end
`endif
        S_ADDR: begin
          tr_rd_data = rd_entry.addr;
          nxt_state  = S_INSN;
        end
        S_INSN: begin
          tr_rd_data = rd_entry.insn;
          tr_rd_last = !has_tval;
          nxt_state  = has_tval ? S_TVAL : S_HDR;
        end
        S_TVAL: begin
          tr_rd_data = rd_entry.tval;
          tr_rd_last = 1'b1;
          nxt_state  = S_HDR;
        end
        default: nxt_state = S_HDR;
      endcase
    end
  end

  assign hs      = tr_rd_valid & tr_rd_ready;
  assign pop_now = hs & tr_rd_last;
  assign push    = trace_en & trace_rv_i_valid_ip & (!full | pop_now) & !tr_clear;
  assign drop_ev = trace_en & trace_rv_i_valid_ip & full & !pop_now & !tr_clear;

  always_comb begin
    wr_entry        = '0;
    wr_entry.addr   = trace_rv_i_address_ip;
    wr_entry.insn   = trace_rv_i_insn_ip;
    wr_entry.tval   = trace_rv_i_tval_ip;
    wr_entry.exc    = trace_rv_i_exception_ip;
    wr_entry.intr   = trace_rv_i_interrupt_ip;
    wr_entry.ecause = trace_rv_i_ecause_ip;
    wr_entry.drop   = drop_q;
`ifdef TRACE_TSTAMP_EN
    wr_entry.tstamp = tstamp_q;
`endif
  end

  always_comb begin
    state_d    = hs ? nxt_state : state_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_now ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_ev;
    drop_d     = drop_q;
    case ({push, pop_now})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // The drop count travels with the next accepted record, then restarts.
    if (push) begin
      drop_d = '0;
    end else if (drop_ev && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
    if (tr_clear) begin
      state_d    = S_HDR;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

`ifdef TRACE_TSTAMP_EN
  assign tstamp_d = tstamp_q + 32'd1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= S_HDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
`ifdef TRACE_TSTAMP_EN
      tstamp_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
`ifdef TRACE_TSTAMP_EN
      tstamp_q   <= tstamp_d;
`endif
    end
  end

  // Storage needs no reset; pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign tr_count    = count_q;
  assign tr_overflow = overflow_q;

endmodule
